// File: rtl/riscv_pkg.sv
// Shared RV32I/RV64I decode constants: opcodes, immediate format encoding,
// shift funct3 values and the skid-buffer state type.
package riscv_pkg;

   localparam int unsigned OPC_W  = 7;
   localparam int unsigned F3_W   = 3;
   localparam int unsigned FMT_W  = 3;
   localparam int unsigned INSN_W = 32;

   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

   // SRLI and SRAI share funct3; inst[30] distinguishes them outside the immediate.
   localparam logic [F3_W-1:0] F3_SLLI = 3'b001;
   localparam logic [F3_W-1:0] F3_SRLI = 3'b101;
   localparam logic [F3_W-1:0] F3_SRAI = 3'b101;

   typedef enum logic [FMT_W-1:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_SH   = 3'd6
   } imm_fmt_e;

   // EMPTY is ST_ONE with the main register invalid.
   typedef enum logic {
      ST_ONE = 1'b0,
      ST_TWO = 1'b1
   } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder and PC-relative target adder; shared with
// the single-cycle core.
module imm_decode
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [INSN_W-1:0] instruction_code,
   input  logic [XLEN-1:0]   pc,
   output logic [XLEN-1:0]   immediate,
   output logic [FMT_W-1:0]  imm_fmt,
   output logic [XLEN-1:0]   target
);

   logic [OPC_W-1:0]   w_opcode;
   logic [F3_W-1:0]    w_funct3;
   logic signed [11:0] w_imm_i;
   logic signed [11:0] w_imm_s;
   logic signed [12:0] w_imm_b;
   logic signed [31:0] w_imm_u;
   logic signed [20:0] w_imm_j;
   logic [5:0]         w_shamt;
   logic               w_pc_rel;
   imm_fmt_e           w_fmt;

   assign w_opcode = instruction_code[6:0];
   assign w_funct3 = instruction_code[14:12];

   // Raw fields are declared signed so the width casts below sign-extend.
   assign w_imm_i = instruction_code[31:20];
   assign w_imm_s = {instruction_code[31:25], instruction_code[11:7]};
   assign w_imm_b = {instruction_code[31], instruction_code[7],
                     instruction_code[30:25], instruction_code[11:8], 1'b0};
   assign w_imm_u = {instruction_code[31:12], 12'h000};
   assign w_imm_j = {instruction_code[31], instruction_code[19:12],
                     instruction_code[20], instruction_code[30:21], 1'b0};

   // Shift amount is unsigned; inst[30] (arithmetic flag) is never included.
   assign w_shamt = (XLEN == 64) ? instruction_code[25:20]
                                 : {1'b0, instruction_code[24:20]};

   always_comb begin
      w_fmt     = FMT_NONE;
      immediate = '0;
      w_pc_rel  = 1'b0;
      case (w_opcode)
         OPC_LOAD, OPC_JALR: begin
            w_fmt     = FMT_I;
            immediate = XLEN'(w_imm_i);
         end
         OPC_OP_IMM: begin
            if (w_funct3 == F3_SLLI || w_funct3 == F3_SRLI) begin
               w_fmt     = FMT_SH;
               immediate = XLEN'(w_shamt);
            end else begin
               w_fmt     = FMT_I;
               immediate = XLEN'(w_imm_i);
            end
         end
         OPC_STORE: begin
            w_fmt     = FMT_S;
            immediate = XLEN'(w_imm_s);
         end
         OPC_BRANCH: begin
            w_fmt     = FMT_B;
            immediate = XLEN'(w_imm_b);
            w_pc_rel  = 1'b1;
         end
         OPC_LUI: begin
            w_fmt     = FMT_U;
            immediate = XLEN'(w_imm_u);
         end
         OPC_AUIPC: begin
            w_fmt     = FMT_U;
            immediate = XLEN'(w_imm_u);
            w_pc_rel  = 1'b1;
         end
         OPC_JAL: begin
            w_fmt     = FMT_J;
            immediate = XLEN'(w_imm_j);
            w_pc_rel  = 1'b1;
         end
         default: begin
            w_fmt     = FMT_NONE;
            immediate = '0;
         end
      endcase
   end

   assign imm_fmt = w_fmt;

   // Wraps modulo 2^XLEN by construction.
   assign target = pc + (w_pc_rel ? immediate : XLEN'(4));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode result stored behind a valid/ready
// handshake with an optional 2-entry skid buffer.
module imm_gen_pipe
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned SKID = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instruction_code,
   input  logic [XLEN-1:0]   pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   immediate,
   output logic [2:0]        imm_fmt,
   output logic [XLEN-1:0]   target,
   output logic [31:0]       instr_out
);

   typedef struct packed {
      logic [INSN_W-1:0] instr;
      logic [XLEN-1:0]   target;
      logic [XLEN-1:0]   imm;
      logic [FMT_W-1:0]  fmt;
   } payload_t;

   logic [XLEN-1:0]  w_dec_imm;
   logic [FMT_W-1:0] w_dec_fmt;
   logic [XLEN-1:0]  w_dec_target;
   payload_t         w_in;

   buf_state_e r_state;
   buf_state_e w_state_nxt;
   logic       r_main_valid;
   logic       w_main_valid_nxt;
   payload_t   r_main;
   payload_t   r_skid;

   logic w_in_ready;
   logic w_accept;
   logic w_deliver;
   logic w_load_main_in;
   logic w_load_main_skid;
   logic w_load_skid;

   imm_decode #(
      .XLEN (XLEN)
   ) u_imm_decode (
      .instruction_code (instruction_code),
      .pc               (pc),
      .immediate        (w_dec_imm),
      .imm_fmt          (w_dec_fmt),
      .target           (w_dec_target)
   );

   assign w_in = '{instr:  instruction_code,
                   target: w_dec_target,
                   imm:    w_dec_imm,
                   fmt:    w_dec_fmt};

   // With the skid buffer, ready comes only from state flops (no out_ready path).
   assign w_in_ready = (SKID != 0) ? (r_state == ST_ONE)
                                   : (!r_main_valid || out_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_deliver  = r_main_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_ONE;
         r_main_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_main_valid <= w_main_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_main_valid_nxt = r_main_valid;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         ST_ONE: begin
            if (w_accept) begin
               if (!r_main_valid || out_ready) begin
                  w_load_main_in   = 1'b1;
                  w_main_valid_nxt = 1'b1;
               end else begin
                  w_load_skid = 1'b1;
                  w_state_nxt = ST_TWO;
               end
            end else if (w_deliver) begin
               w_main_valid_nxt = 1'b0;
            end
         end
         ST_TWO: begin
            // Main is always valid here; in_ready is low so no accept.
            if (out_ready) begin
               w_load_main_skid = 1'b1;
               w_state_nxt      = ST_ONE;
            end
         end
         default: begin
            w_state_nxt      = ST_ONE;
            w_main_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main_in) begin
            r_main <= w_in;
         end else if (w_load_main_skid) begin
            r_main <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= w_in;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_main_valid;
   assign immediate = r_main.imm;
   assign imm_fmt   = r_main.fmt;
   assign target    = r_main.target;
   assign instr_out = r_main.instr;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode vectors on XLEN=32/64 instances,
// skid backpressure ordering and asynchronous reset from the full state.
module tb_imm_gen_pipe;

   logic clk;
   logic rst_n;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_instr, a_pc, a_imm, a_target, a_instr_out;
   logic [2:0]  a_fmt;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_instr, b_instr_out;
   logic [63:0] b_pc, b_imm, b_target;
   logic [2:0]  b_fmt;

   int checks;
   int failures;

   imm_gen_pipe #(.XLEN(32), .SKID(1)) u_dut32 (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (a_in_valid),
      .in_ready         (a_in_ready),
      .instruction_code (a_instr),
      .pc               (a_pc),
      .out_valid        (a_out_valid),
      .out_ready        (a_out_ready),
      .immediate        (a_imm),
      .imm_fmt          (a_fmt),
      .target           (a_target),
      .instr_out        (a_instr_out)
   );

   imm_gen_pipe #(.XLEN(64), .SKID(1)) u_dut64 (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (b_in_valid),
      .in_ready         (b_in_ready),
      .instruction_code (b_instr),
      .pc               (b_pc),
      .out_valid        (b_out_valid),
      .out_ready        (b_out_ready),
      .immediate        (b_imm),
      .imm_fmt          (b_fmt),
      .target           (b_target),
      .instr_out        (b_instr_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send32(input logic [31:0] ins, input logic [31:0] p);
      a_in_valid = 1'b1;
      a_instr    = ins;
      a_pc       = p;
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
   endtask

   task automatic send64(input logic [31:0] ins, input logic [63:0] p);
      b_in_valid = 1'b1;
      b_instr    = ins;
      b_pc       = p;
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
   endtask

   task automatic dec32(input string tag, input logic [31:0] imm,
                        input logic [2:0] fmt, input logic [31:0] tgt);
      chk({tag, "_valid"}, 64'(a_out_valid), 64'd1);
      chk({tag, "_imm"},   64'(a_imm),       64'(imm));
      chk({tag, "_fmt"},   64'(a_fmt),       64'(fmt));
      chk({tag, "_tgt"},   64'(a_target),    64'(tgt));
   endtask

   task automatic dec64(input string tag, input logic [63:0] imm,
                        input logic [2:0] fmt, input logic [63:0] tgt);
      chk({tag, "_valid"}, 64'(b_out_valid), 64'd1);
      chk({tag, "_imm"},   b_imm,            imm);
      chk({tag, "_fmt"},   64'(b_fmt),       64'(fmt));
      chk({tag, "_tgt"},   b_target,         tgt);
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      a_instr     = '0;
      a_pc        = '0;
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      b_instr     = '0;
      b_pc        = '0;

      // Reset state
      @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(a_out_valid), 64'd0);
      chk("rst_in_ready",  64'(a_in_ready),  64'd1);
      chk("rst_imm",       64'(a_imm),       64'd0);
      chk("rst_tgt",       64'(a_target),    64'd0);
      chk("rst_fmt",       64'(a_fmt),       64'd0);
      chk("rst_instr",     64'(a_instr_out), 64'd0);
      chk("rst64_valid",   64'(b_out_valid), 64'd0);
      rst_n = 1'b1;

      // XLEN=32 decode vectors, out_ready held high (1 per cycle)
      send32(32'hFFF0_0093, 32'h0000_0200);
      dec32("addi_m1", 32'hFFFF_FFFF, 3'd1, 32'h0000_0204);
      chk("addi_instr_out", 64'(a_instr_out), 64'hFFF0_0093);
      send32(32'hFE00_0EE3, 32'h0000_0100);
      dec32("beq_m4", 32'hFFFF_FFFC, 3'd3, 32'h0000_00FC);
      send32(32'hFE00_0EE3, 32'h0000_0000);
      dec32("beq_wrap", 32'hFFFF_FFFC, 3'd3, 32'hFFFF_FFFC);
      send32(32'h1234_50B7, 32'h0000_0300);
      dec32("lui", 32'h1234_5000, 3'd4, 32'h0000_0304);
      send32(32'h0000_1097, 32'h0000_1000);
      dec32("auipc", 32'h0000_1000, 3'd4, 32'h0000_2000);
      send32(32'h0080_00EF, 32'h0000_0040);
      dec32("jal8", 32'h0000_0008, 3'd5, 32'h0000_0048);
      send32(32'hFE20_AC23, 32'h0000_0010);
      dec32("sw_m8", 32'hFFFF_FFF8, 3'd2, 32'h0000_0014);
      send32(32'h01F0_9093, 32'h0000_0020);
      dec32("slli31", 32'h0000_001F, 3'd6, 32'h0000_0024);
      send32(32'h41F0_D093, 32'h0000_0020);
      dec32("srai31", 32'h0000_001F, 3'd6, 32'h0000_0024);
      @(posedge clk);
      #1;
      chk("drain_out_valid", 64'(a_out_valid), 64'd0);

      // XLEN=64 decode vectors
      send64(32'h8000_00B7, 64'h0000_0001_0000_0000);
      dec64("lui64", 64'hFFFF_FFFF_8000_0000, 3'd4, 64'h0000_0001_0000_0004);
      send64(32'h03F0_9093, 64'h0000_0001_0000_0000);
      dec64("slli63", 64'd63, 3'd6, 64'h0000_0001_0000_0004);
      send64(32'h43F0_D093, 64'h0000_0001_0000_0000);
      dec64("srai63", 64'd63, 3'd6, 64'h0000_0001_0000_0004);
      send64(32'h0000_007F, 64'h0000_0001_0000_0000);
      dec64("opc7f", 64'd0, 3'd0, 64'h0000_0001_0000_0004);
      send64(32'hFE00_0EE3, 64'h0000_0000_0000_0000);
      dec64("beq64_wrap", 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC);
      @(posedge clk);
      #1;

      // Backpressure: A, B, C with out_ready low for three edges
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_instr     = 32'h0010_0093;
      a_pc        = 32'h0000_0400;
      @(posedge clk);
      #1;
      chk("bp_ready_after_A", 64'(a_in_ready), 64'd1);
      chk("bp_main_A",        64'(a_instr_out), 64'h0010_0093);
      a_instr = 32'h0020_0093;
      @(posedge clk);
      #1;
      chk("bp_ready_after_B", 64'(a_in_ready), 64'd0);
      chk("bp_hold_A",        64'(a_instr_out), 64'h0010_0093);
      a_instr = 32'h0030_0093;
      @(posedge clk);
      #1;
      chk("bp_C_waits_ready", 64'(a_in_ready),  64'd0);
      chk("bp_C_waits_valid", 64'(a_out_valid), 64'd1);
      chk("bp_still_A",       64'(a_instr_out), 64'h0010_0093);
      a_out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_deliver_B",     64'(a_instr_out), 64'h0020_0093);
      chk("bp_B_imm",         64'(a_imm),       64'd2);
      chk("bp_ready_back",    64'(a_in_ready),  64'd1);
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      chk("bp_deliver_C",     64'(a_instr_out), 64'h0030_0093);
      chk("bp_C_valid",       64'(a_out_valid), 64'd1);
      chk("bp_C_imm",         64'(a_imm),       64'd3);
      @(posedge clk);
      #1;
      chk("bp_empty",         64'(a_out_valid), 64'd0);

      // Async reset from state TWO
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_instr     = 32'h0050_0093;
      @(posedge clk);
      #1;
      a_instr = 32'h0060_0093;
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      chk("two_ready_low", 64'(a_in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(a_out_valid), 64'd0);
      chk("arst_in_ready",  64'(a_in_ready),  64'd1);
      chk("arst_imm",       64'(a_imm),       64'd0);
      chk("arst_tgt",       64'(a_target),    64'd0);
      chk("arst_fmt",       64'(a_fmt),       64'd0);
      chk("arst_instr",     64'(a_instr_out), 64'd0);
      #1;
      rst_n       = 1'b1;
      a_out_ready = 1'b1;
      send32(32'h0070_0093, 32'h0000_0500);
      chk("post_rst_first",  64'(a_instr_out), 64'h0070_0093);
      chk("post_rst_valid",  64'(a_out_valid), 64'd1);
      @(posedge clk);
      #1;
      chk("post_rst_no_dup", 64'(a_out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined successor to the single-cycle immediate generator. It decodes every RV32I/RV64I immediate format, including U-type and shift-amount immediates, and computes the PC-relative target. Results are registered behind a valid/ready handshake with a 2-entry skid buffer, so the block sits between fetch and execute in the pipelined core without a combinational path from downstream `out_ready` to upstream `in_ready`.

## Interface
- `XLEN`, default 32: datapath width; legal values 32 or 64.
- `SKID`, default 1: 1 = 2-entry skid buffer (full throughput); 0 = single register (`in_ready = !out_valid | out_ready`).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  block accepts this cycle.
- `instruction_code`  in  32  raw instruction word.
- `pc`  in  XLEN  address of the instruction.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts.
- `immediate`  out  XLEN  sign/zero-extended immediate.
- `imm_fmt`  out  3  format: NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6.
- `target`  out  XLEN  `pc+immediate` for B/J/AUIPC; `pc+4` otherwise.
- `instr_out`  out  32  instruction passed through with its result.

## Operation
- Decode by opcode [6:0]:
  - LOAD 0000011, JALR 1100111 → I.
  - OP-IMM 0010011 → I, except funct3 001/101 → SH.
  - STORE 0100011 → S.
  - BRANCH 1100011 → B.
  - LUI 0110111, AUIPC 0010111 → U.
  - JAL 1101111 → J.
  - Any other opcode → NONE, immediate 0.
- I: sext(inst[31:20]).
- S: sext({inst[31:25], inst[11:7]}).
- B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
- U: sext({inst[31:12], 12'h0}); for XLEN=64, bit 31 is replicated.
- J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
- SH: zero-extended shamt; inst[24:20] for XLEN=32, inst[25:20] for XLEN=64. inst[30] (arith flag) never appears in the immediate.
- `target` adder is XLEN wide and wraps modulo 2^XLEN; no overflow flag.
- A transfer occurs on `in_valid & in_ready` (accept) and on `out_valid & out_ready` (deliver).
- Buffer (SKID=1) has two states:
  - ONE: main register valid, skid empty.
  - TWO: both valid.
  - EMPTY is ONE with `out_valid=0`.
- `in_ready = !skid_valid` (registered).
- Accept while the main register is empty or delivering → write the main register.
- Accept while the main register is stalled → write the skid register.
- Deliver while the skid is full → skid moves into the main register and the skid clears.
- Order is strictly FIFO; no result is dropped or duplicated.
- `in_valid` may fall without a transfer (no upstream hold requirement). Once `out_valid` is high, the outputs stay stable until delivered.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 per cycle while `out_ready` is high.
- Reset (async assert, sync release): `out_valid=0`, `in_ready=1`, skid empty, `immediate=0`, `target=0`, `imm_fmt=NONE`, `instr_out=0`.
- Reset mid-transfer discards both buffered entries. The first accept is allowed in the first cycle after `rst_n` deasserts.
- Simultaneous accept and deliver in state ONE: the main register reloads, the skid stays empty, and `out_valid` stays 1.
- Simultaneous accept and deliver in state TWO cannot occur (`in_ready=0`).
- `in_ready` depends only on flops, never combinationally on `out_ready`.

## Structure
- `riscv_pkg` (shared) holds:
  - opcode constants (LOAD, STORE, BRANCH, OP_IMM, JAL, JALR, LUI, AUIPC);
  - the `imm_fmt` encoding;
  - funct3 values for SLLI/SRLI/SRAI.
- `imm_decode` (combinational, parametrised by XLEN) takes `instruction_code` and `pc` and produces `immediate`, `imm_fmt` and `target`. It is reused by the single-cycle core.
- `imm_gen_pipe` itself contains only the handshake and storage.

## Test plan
- XLEN=32, `instruction_code` 0xFFF00093 (addi x1,x0,-1) → `immediate` 0xFFFFFFFF, `imm_fmt`=I, `target`=`pc+4`.
- XLEN=32, 0xFE000EE3 (beq -4) with `pc`=0x100 → `immediate` 0xFFFFFFFC, `imm_fmt`=B, `target` 0x000000FC. With `pc`=0x0 → `target` 0xFFFFFFFC (wrap).
- 0x123450B7 (lui) → `immediate` 0x12345000 (XLEN=32). 0x800000B7 with XLEN=64 → 0xFFFFFFFF80000000.
- XLEN=64:
  - 0x03F09093 (slli 63) → `immediate` 63, `imm_fmt`=SH.
  - 0x43F0D093 (srai 63) → `immediate` 63.
  - Opcode 0x7F → `immediate` 0, `imm_fmt`=NONE.
- Backpressure, SKID=1: stream A, B, C with `out_ready` held low for 3 cycles → `in_ready` falls the cycle after B is accepted and C waits. On release, A, B, C are delivered in consecutive cycles.
- Pull `rst_n` low asynchronously while in state TWO → `out_valid` and all outputs reach their reset values without a clock edge, and the next accepted instruction is the first one delivered.
